// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 controller: FSM encoding, opcodes,
// panel command bytes and the opcode mnemonic table.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, IDLE, CONV, WRITE, EN_HI, EN_WAIT
    } lcd_state_e;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_CLR, OP_DISP
    } lcd_opcode_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [3:0][7:0] INIT_CMDS = {CMD_ENTRY, CMD_CLEAR, CMD_DISP_ON, CMD_FUNC_SET};

    // Element 0 is the last entry of the concatenation, so this indexes by opcode.
    localparam logic [7:0][31:0] MNEM_TBL = {"DISP", "CLR ", "MUL ", "SUBI",
                                             "SUB ", "ADDI", "ADD ", "LOAD"};

    localparam int BCD_DIGITS = 5;

    function automatic logic [7:0] mnem_char(input logic [2:0] op, input logic [1:0] pos);
        logic [31:0] word;
        word = MNEM_TBL[op];
        return word[{~pos, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] dig_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

endpackage

// File: rtl/module_lcd_bin2bcd.sv
// Sequential double-dabble: 16-bit binary to five BCD digits, one shift per cycle,
// done pulses one cycle after the sixteenth shift.
module module_lcd_bin2bcd
    import lcd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic [19:0] bcd_o,
    output logic        done_o
);
    logic [35:0] sr_q, sr_d, adj, shifted;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [19:0] bcd_q, bcd_d;

    always_comb begin
        adj = sr_q;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (sr_q[16 + 4*d +: 4] >= 4'd5) adj[16 + 4*d +: 4] = sr_q[16 + 4*d +: 4] + 4'd3;
        end
        shifted = adj << 1;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        if (start_i && !busy_q) begin
            sr_d   = {20'd0, bin_i};
            cnt_d  = 4'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d  = shifted;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                bcd_d  = shifted[35:16];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            bcd_q  <= bcd_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = done_q;

endmodule

// File: rtl/module_lcd_ctrl.sv
// HD44780 8-bit write-only controller: power-up init, then a 34-byte two-line frame
// (mnemonic/register, signed value) per request. LCD_FAST_SIM_EN shrinks all delays.
module module_lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_update,
    input  logic [2:0]  lcd_opcode,
    input  logic [3:0]  lcd_reg_idx,
    input  logic [15:0] lcd_value,
    output logic        lcd_busy,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    output logic        LCD_ON
);
`ifdef LCD_FAST_SIM_EN
    localparam logic [31:0] T_PWR = 32'd16;
    localparam logic [31:0] T_EN  = 32'd2;
    localparam logic [31:0] T_CMD = 32'd4;
    localparam logic [31:0] T_CLR = 32'd8;
`else
    localparam logic [63:0] HZ    = 64'(CLK_HZ);
    localparam logic [31:0] T_PWR = 32'((HZ * 64'd20 + 64'd999) / 64'd1000);
    localparam logic [31:0] T_EN  = 32'((HZ + 64'd999_999) / 64'd1_000_000);
    localparam logic [31:0] T_CMD = 32'((HZ * 64'd50 + 64'd999_999) / 64'd1_000_000);
    localparam logic [31:0] T_CLR = 32'((HZ * 64'd2 + 64'd999) / 64'd1000);
`endif

    lcd_state_e  state_q, state_d;
    logic [31:0] dly_q, dly_d, wait_len;
    logic [5:0]  byte_q, byte_d;
    logic        wr_phase_q, wr_phase_d;
    logic [2:0]  op_q;
    logic [3:0]  reg_q;
    logic [15:0] val_q, abs_val;
    logic [19:0] bcd;
    logic        bcd_done, bcd_start, accept, last_byte, xfer;
    logic [7:0]  cur_byte;
    logic        cur_rs;
    logic [3:0]  l1pos, l2pos;

    assign accept    = (state_q == IDLE) && lcd_update;
    assign abs_val   = val_q[15] ? (~val_q + 16'd1) : val_q;
    assign bcd_start = (state_q == CONV) && (dly_q == 32'd0);
    assign last_byte = wr_phase_q ? (byte_q == 6'd33) : (byte_q == 6'd3);
    assign xfer      = (state_q == INIT) || (state_q == WRITE) ||
                       (state_q == EN_HI) || (state_q == EN_WAIT);
    assign wait_len  = (!cur_rs && cur_byte == CMD_CLEAR) ? T_CLR : T_CMD;

    module_lcd_bin2bcd u_bcd (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (bcd_start),
        .bin_i   (abs_val),
        .bcd_o   (bcd),
        .done_o  (bcd_done)
    );

    // Byte under transfer: init command, or frame byte 0..33 (0x80, line 1, 0xC0, line 2).
    always_comb begin
        cur_byte = 8'h20;
        cur_rs   = 1'b1;
        l1pos    = 4'(byte_q - 6'd1);
        l2pos    = 4'(byte_q - 6'd18);
        if (!wr_phase_q) begin
            cur_byte = INIT_CMDS[byte_q[1:0]];
            cur_rs   = 1'b0;
        end else if (byte_q == 6'd0) begin
            cur_byte = CMD_LINE1;
            cur_rs   = 1'b0;
        end else if (byte_q == 6'd17) begin
            cur_byte = CMD_LINE2;
            cur_rs   = 1'b0;
        end else if (byte_q < 6'd17) begin
            if (l1pos < 4'd4)       cur_byte = mnem_char(op_q, l1pos[1:0]);
            else if (l1pos == 4'd5) cur_byte = "R";
            else if (l1pos == 4'd6) cur_byte = (reg_q >= 4'd10) ? "1" : "0";
            else if (l1pos == 4'd7) cur_byte = dig_char((reg_q >= 4'd10) ? reg_q - 4'd10 : reg_q);
        end else begin
            case (l2pos)
                4'd0:    cur_byte = val_q[15] ? "-" : "+";
                4'd1:    cur_byte = dig_char(bcd[19:16]);
                4'd2:    cur_byte = dig_char(bcd[15:12]);
                4'd3:    cur_byte = dig_char(bcd[11:8]);
                4'd4:    cur_byte = dig_char(bcd[7:4]);
                4'd5:    cur_byte = dig_char(bcd[3:0]);
                default: cur_byte = 8'h20;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= PWR_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PWR_WAIT: if (dly_q == T_PWR - 32'd1) state_d = INIT;
            INIT:     state_d = EN_HI;
            IDLE:     if (lcd_update) state_d = CONV;
            CONV:     if (bcd_done) state_d = WRITE;
            WRITE:    state_d = EN_HI;
            EN_HI:    if (dly_q == T_EN - 32'd1) state_d = EN_WAIT;
            EN_WAIT: begin
                if (dly_q == wait_len - 32'd1) begin
                    if (last_byte)       state_d = IDLE;
                    else if (wr_phase_q) state_d = WRITE;
                    else                 state_d = INIT;
                end
            end
            default:  state_d = PWR_WAIT;
        endcase
    end

    always_comb begin
        lcd_busy = (state_q != IDLE);
        LCD_EN   = (state_q == EN_HI);
        LCD_RW   = 1'b0;
        LCD_ON   = 1'b1;
        LCD_RS   = 1'b0;
        LCD_DATA = 8'h00;
        if (xfer) begin
            LCD_RS   = cur_rs;
            LCD_DATA = cur_byte;
        end
    end

    // Delay counter restarts on every state change; byte counter holds at its last index.
    always_comb begin
        dly_d      = (state_d != state_q || state_q == IDLE) ? 32'd0 : dly_q + 32'd1;
        byte_d     = byte_q;
        wr_phase_d = wr_phase_q;
        if (accept) begin
            byte_d     = 6'd0;
            wr_phase_d = 1'b1;
        end else if (state_q == EN_WAIT && state_d != EN_WAIT && !last_byte) begin
            byte_d = byte_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q      <= '0;
            byte_q     <= '0;
            wr_phase_q <= 1'b0;
            op_q       <= '0;
            reg_q      <= '0;
            val_q      <= '0;
        end else begin
            dly_q      <= dly_d;
            byte_q     <= byte_d;
            wr_phase_q <= wr_phase_d;
            if (accept) begin
                op_q  <= lcd_opcode;
                reg_q <= lcd_reg_idx;
                val_q <= lcd_value;
            end
        end
    end

endmodule

// File: tb/tb_module_lcd_ctrl.sv
// Directed bench for module_lcd_ctrl: init sequence, frame contents, strobe timing,
// ignored mid-frame requests and reset during a frame.
module tb_module_lcd_ctrl;
    localparam int CLK_HZ = 1_200_000;
`ifdef LCD_FAST_SIM_EN
    localparam int T_PWR = 16;
    localparam int T_EN  = 2;
    localparam int T_CMD = 4;
    localparam int T_CLR = 8;
`else
    // 1.2 MHz: 20 ms, 1 us (1.2 rounded up), 50 us, 2 ms.
    localparam int T_PWR = 24000;
    localparam int T_EN  = 2;
    localparam int T_CMD = 60;
    localparam int T_CLR = 2400;
`endif
    localparam int BYTE_CYC     = 1 + T_EN + T_CMD;
    localparam int FRAME_BUDGET = 200 + 34 * BYTE_CYC;
    localparam int INIT_BUDGET  = T_PWR + T_CLR + 4 * BYTE_CYC + 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lcd_update = 1'b0;
    logic [2:0]  lcd_opcode = '0;
    logic [3:0]  lcd_reg_idx = '0;
    logic [15:0] lcd_value = '0;
    logic        lcd_busy, LCD_RS, LCD_RW, LCD_EN, LCD_ON;
    logic [7:0]  LCD_DATA;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_data[64];
    logic       cap_rs[64];
    bit         cap_setup[64];
    int         cap_w[64], cap_gap[64], cap_hold[64];
    int         cap_cnt, cap_first, cap_busy_low, cap_en_bad;
    bit         cap_timeout;

    logic [7:0] exp_b[34];
    logic       exp_rs[34];
    logic [7:0] init_exp[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    module_lcd_ctrl #(.CLK_HZ(CLK_HZ)) dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_update  (lcd_update),
        .lcd_opcode  (lcd_opcode),
        .lcd_reg_idx (lcd_reg_idx),
        .lcd_value   (lcd_value),
        .lcd_busy    (lcd_busy),
        .LCD_DATA    (LCD_DATA),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_EN      (LCD_EN),
        .LCD_ON      (LCD_ON)
    );

    always #5 clk = ~clk;

    // Records up to n strobes (byte, RS, width, setup, gap to next rise, hold after fall);
    // stops once the last byte's data changes or an extra strobe begins.
    task automatic capture(input int n, input int budget);
        logic pe, pr, holding, fell;
        logic [7:0] pd;
        int gap, cur;
        cap_cnt = 0; cap_first = 0; cap_busy_low = 0; cap_en_bad = 0; cap_timeout = 0;
        pe = LCD_EN; pd = LCD_DATA; pr = LCD_RS;
        holding = 0; fell = 0; gap = 0; cur = 0;
        for (int cyc = 1; cyc <= budget + 1; cyc++) begin
            @(negedge clk);
            if (cyc > budget) begin cap_timeout = 1; break; end
            if (LCD_EN && !pe) begin
                if (cap_cnt > 0) cap_gap[cap_cnt-1] = gap;
                if (cap_cnt >= n) break;
                holding = 0; fell = 0;
                if (cap_cnt == 0) cap_first = cyc;
                cur = cap_cnt;
                cap_data[cur] = LCD_DATA; cap_rs[cur] = LCD_RS;
                cap_setup[cur] = (pd === LCD_DATA) && (pr === LCD_RS);
                cap_w[cur] = 0; cap_hold[cur] = 0;
                cap_cnt++;
            end
            if (LCD_EN) begin
                cap_w[cur]++;
                if (LCD_DATA !== cap_data[cur] || LCD_RS !== cap_rs[cur]) cap_en_bad++;
            end else if (pe) begin
                fell = 1; holding = 1; gap = 0;
            end
            if (!LCD_EN && fell) begin
                gap++;
                if (holding && LCD_DATA === cap_data[cur] && LCD_RS === cap_rs[cur]) cap_hold[cur]++;
                else holding = 0;
            end
            pe = LCD_EN; pd = LCD_DATA; pr = LCD_RS;
            if (cap_cnt == n && fell && !holding) break;
            if (!lcd_busy) cap_busy_low++;
        end
    endtask

    task automatic count_en(input int window, output int n);
        logic pe;
        n = 0; pe = LCD_EN;
        repeat (window) begin
            @(negedge clk);
            if (LCD_EN && !pe) n++;
            pe = LCD_EN;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] r, input logic [15:0] v);
        @(negedge clk);
        lcd_opcode = op; lcd_reg_idx = r; lcd_value = v; lcd_update = 1'b1;
        @(negedge clk);
        lcd_update = 1'b0; lcd_opcode = 3'd7; lcd_reg_idx = 4'd14; lcd_value = 16'h5A5A;
    endtask

    task automatic build_frame(input string l1, input string l2);
        for (int i = 0; i < 34; i++) begin exp_b[i] = 8'h20; exp_rs[i] = 1'b1; end
        exp_b[0] = 8'h80; exp_rs[0] = 1'b0;
        exp_b[17] = 8'hC0; exp_rs[17] = 1'b0;
        for (int i = 0; i < l1.len(); i++) exp_b[1+i] = l1[i];
        for (int i = 0; i < l2.len(); i++) exp_b[18+i] = l2[i];
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks += 6;
        if (lcd_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", lcd_busy); end
        if (LCD_EN !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", LCD_EN); end
        if (LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_rs got %b exp 0", LCD_RS); end
        if (LCD_RW !== 1'b0) begin errors++; $display("FAIL reset_rw got %b exp 0", LCD_RW); end
        if (LCD_ON !== 1'b1) begin errors++; $display("FAIL reset_on got %b exp 1", LCD_ON); end
        if (LCD_DATA !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", LCD_DATA); end
    endtask

    task automatic test_init(input string tag);
        @(negedge clk);
        rst = 1'b0;
        capture(4, INIT_BUDGET);
        checks++;
        if (cap_timeout || cap_cnt != 4) begin
            errors++; $display("FAIL %s_count got %0d exp 4 (timeout=%0d)", tag, cap_cnt, cap_timeout);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== init_exp[i] || cap_rs[i] !== 1'b0) begin
                errors++; $display("FAIL %s_byte%0d got %h/rs%b exp %h/rs0", tag, i, cap_data[i], cap_rs[i], init_exp[i]);
            end
        end
        checks += 5;
        if (cap_first != T_PWR + 1) begin errors++; $display("FAIL %s_pwr_delay got %0d exp %0d", tag, cap_first, T_PWR + 1); end
        if (cap_gap[0] != T_CMD + 1) begin errors++; $display("FAIL %s_gap_cmd got %0d exp %0d", tag, cap_gap[0], T_CMD + 1); end
        if (cap_gap[2] != T_CLR + 1) begin errors++; $display("FAIL %s_gap_clr got %0d exp %0d", tag, cap_gap[2], T_CLR + 1); end
        if (cap_busy_low != 0) begin errors++; $display("FAIL %s_busy_during got %0d low cycles exp 0", tag, cap_busy_low); end
        if (lcd_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after got %b exp 0", tag, lcd_busy); end
    endtask

    task automatic test_frames;
        logic [2:0]  ops[4]  = '{3'b001, 3'b100, 3'b111, 3'b110};
        logic [3:0]  regs[4] = '{4'd5, 4'd15, 4'd0, 4'd10};
        logic [15:0] vals[4] = '{16'd42, 16'h8000, 16'hFFFF, 16'h0000};
        string       l1s[4]  = '{"ADD  R05", "SUBI R15", "DISP R00", "CLR  R10"};
        string       l2s[4]  = '{"+00042", "-32768", "-00001", "+00000"};
        for (int k = 0; k < 4; k++) begin
            send(ops[k], regs[k], vals[k]);
            checks++;
            if (lcd_busy !== 1'b1) begin errors++; $display("FAIL frame%0d_busy_rise got %b exp 1", k, lcd_busy); end
            build_frame(l1s[k], l2s[k]);
            capture(34, FRAME_BUDGET);
            checks++;
            if (cap_timeout || cap_cnt != 34) begin
                errors++; $display("FAIL frame%0d_count got %0d exp 34 (timeout=%0d)", k, cap_cnt, cap_timeout);
            end
            for (int i = 0; i < 34; i++) begin
                checks++;
                if (cap_data[i] !== exp_b[i] || cap_rs[i] !== exp_rs[i]) begin
                    errors++;
                    $display("FAIL frame%0d_byte%0d got %h/rs%b exp %h/rs%b", k, i, cap_data[i], cap_rs[i], exp_b[i], exp_rs[i]);
                end
            end
            checks += 2;
            if (cap_busy_low != 0) begin errors++; $display("FAIL frame%0d_busy_during got %0d exp 0", k, cap_busy_low); end
            if (lcd_busy !== 1'b0) begin errors++; $display("FAIL frame%0d_busy_after got %b exp 0", k, lcd_busy); end
        end
    endtask

    task automatic test_timing;
        send(3'b000, 4'd9, 16'd12345);
        build_frame("LOAD R09", "+12345");
        capture(34, FRAME_BUDGET);
        checks += 2;
        if (cap_timeout || cap_cnt != 34) begin errors++; $display("FAIL timing_count got %0d exp 34", cap_cnt); end
        if (cap_en_bad != 0) begin errors++; $display("FAIL timing_data_during_en got %0d changes exp 0", cap_en_bad); end
        for (int i = 0; i < 34; i++) begin
            checks += 4;
            if (cap_data[i] !== exp_b[i] || cap_rs[i] !== exp_rs[i]) begin
                errors++; $display("FAIL timing_byte%0d got %h exp %h", i, cap_data[i], exp_b[i]);
            end
            if (cap_w[i] != T_EN) begin errors++; $display("FAIL timing_en_width%0d got %0d exp %0d", i, cap_w[i], T_EN); end
            if (!cap_setup[i]) begin errors++; $display("FAIL timing_setup%0d got unstable exp stable", i); end
            if (cap_hold[i] < T_CMD) begin errors++; $display("FAIL timing_hold%0d got %0d exp >=%0d", i, cap_hold[i], T_CMD); end
            if (i < 33) begin
                checks++;
                if (cap_gap[i] != T_CMD + 1) begin errors++; $display("FAIL timing_gap%0d got %0d exp %0d", i, cap_gap[i], T_CMD + 1); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int extra;
        send(3'b011, 4'd3, 16'hFED4);
        build_frame("SUB  R03", "-00300");
        fork
            capture(34, FRAME_BUDGET);
            begin
                repeat (20 + 5 * BYTE_CYC) @(negedge clk);
                lcd_opcode = 3'b101; lcd_reg_idx = 4'd7; lcd_value = 16'd999; lcd_update = 1'b1;
                @(negedge clk);
                lcd_update = 1'b0;
            end
        join
        checks++;
        if (cap_timeout || cap_cnt != 34) begin errors++; $display("FAIL b2b_count got %0d exp 34", cap_cnt); end
        for (int i = 0; i < 34; i++) begin
            checks++;
            if (cap_data[i] !== exp_b[i] || cap_rs[i] !== exp_rs[i]) begin
                errors++; $display("FAIL b2b_byte%0d got %h/rs%b exp %h/rs%b", i, cap_data[i], cap_rs[i], exp_b[i], exp_rs[i]);
            end
        end
        count_en(3 * BYTE_CYC + 40, extra);
        checks += 2;
        if (extra != 0) begin errors++; $display("FAIL b2b_second_frame got %0d strobes exp 0", extra); end
        if (lcd_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b exp 0", lcd_busy); end
    endtask

    task automatic test_reset_mid;
        int extra;
        send(3'b001, 4'd5, 16'd42);
        build_frame("ADD  R05", "+00042");
        capture(10, FRAME_BUDGET);
        checks += 2;
        if (cap_timeout || cap_cnt != 10) begin errors++; $display("FAIL rstmid_count got %0d exp 10", cap_cnt); end
        if (cap_data[9] !== exp_b[9]) begin errors++; $display("FAIL rstmid_byte9 got %h exp %h", cap_data[9], exp_b[9]); end
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (LCD_EN !== 1'b0) begin errors++; $display("FAIL rstmid_en got %b exp 0", LCD_EN); end
        if (lcd_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", lcd_busy); end
        if (LCD_DATA !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", LCD_DATA); end
        rst = 1'b0;
        capture(4, INIT_BUDGET);
        checks += 2;
        if (cap_timeout || cap_cnt != 4) begin errors++; $display("FAIL rstmid_init_count got %0d exp 4", cap_cnt); end
        if (cap_first != T_PWR + 1) begin errors++; $display("FAIL rstmid_pwr_delay got %0d exp %0d", cap_first, T_PWR + 1); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== init_exp[i] || cap_rs[i] !== 1'b0) begin
                errors++; $display("FAIL rstmid_init%0d got %h/rs%b exp %h/rs0", i, cap_data[i], cap_rs[i], init_exp[i]);
            end
        end
        count_en(3 * BYTE_CYC + 40, extra);
        checks += 2;
        if (extra != 0) begin errors++; $display("FAIL rstmid_leftover got %0d strobes exp 0", extra); end
        if (lcd_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b exp 0", lcd_busy); end
    endtask

    initial begin
        test_reset();
        test_init("init");
        test_frames();
        test_timing();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
